cp0: RTL and testbench
======================

# cp0

Coprocessor-0 for the pipelined MIPS core: holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against synchronous exceptions reported by the M stage, and drives the PC register's `IntExc` and `EPCout` inputs. It sits beside the M stage, directly upstream of the PC register. It also serves `mfc0`/`mtc0` accesses from the M stage.

## Interface
Parameters:
- `PRID`, default 32'h2019_0701: read-only value of the PRId register.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; sampled only at posedge `clk`.
- `we`  in  1  `mtc0` write enable (M stage).
- `addr`  in  5  CP0 register number (rd field).
- `wdata`  in  32  `mtc0` data.
- `rdata`  out  32  `mfc0` data, combinational from `addr`.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `ExcCode_in`  in  5  exception code of the M-stage instruction; 0 means none.
- `BD_in`  in  1  M-stage instruction is in a branch delay slot.
- `PC_in`  in  32  PC of the M-stage instruction.
- `eret`  in  1  `eret` in M stage.
- `IntExc`  out  1  take interrupt/exception this cycle; goes to the PC register.
- `EPCout`  out  32  return address for `eret`; goes to the PC register.

## Operation
- Register map:
  - 12 = SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - 13 = Cause: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - 14 = EPC: bits [1:0] always 0.
  - 15 = PRId.
  - Any other address reads 0.
- int_req = IE & ~EXL & |(HWInt & IM).
- exc_req = (ExcCode_in != 0) & ~EXL.
- IntExc = (int_req | exc_req) & reset. It is combinational from the current state and the inputs.
- Priority: interrupt wins over exception. The recorded ExcCode is 0 on an interrupt, otherwise ExcCode_in.
- On IntExc, at the next edge:
  - EXL <= 1.
  - Cause.ExcCode <= selected code.
  - Cause.BD <= BD_in.
  - EPC <= (BD_in ? PC_in - 4 : PC_in) with [1:0] cleared.
- Cause.IP <= HWInt every cycle, regardless of EXL or IE.
- `eret` with IntExc = 0: EXL <= 0 at the next edge.
- `mtc0`:
  - Applies only when IntExc = 0.
  - Writes to SR update only IM, EXL and IE.
  - Writes to Cause are ignored; Cause is read-only to software.
  - Writes to EPC store wdata[31:2] with [1:0] = 00.
  - Writes to PRId are ignored.
- EPCout forwarding: if we=1, addr=14 and IntExc=0, EPCout = {wdata[31:2],2'b00}; otherwise EPCout = EPC.
- Simultaneous events:
  - IntExc + eret: the exception path wins and EXL stays 1.
  - IntExc + mtc0: the write is dropped.
  - eret + mtc0 to SR: the written EXL is applied, then eret clears EXL.

## Timing
- Reset (reset=0 at posedge): SR, Cause and EPC clear to 0.
  - While reset=0: IntExc = 0, rdata follows the registers, EPCout = 0 after the first edge.
- Zero-cycle latency from a request to IntExc. State commits one edge later.
- Nested exceptions while EXL=1 are masked; no state is recorded.
- EPC arithmetic is 32-bit modulo. PC_in = 0 with BD_in = 1 wraps to 32'hFFFF_FFFC.
- Reset mid-handler (EXL=1) returns all registers to 0 at that edge.

## Structure
- Shared package `cp0_pkg`:
  - Register-number constants: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - Field bit positions for IM, EXL, IE, BD, IP and ExcCode.
- Single flat module with no sub-modules. The request/priority logic stays inline.

## Test plan
- Reset low for 2 cycles, then SR=32'h0000_FC01 via mtc0, then HWInt=6'b000100 -> IntExc=1 the same cycle. Next edge: EXL=1, Cause=32'h0000_1000, EPC=PC_in.
- ExcCode_in=10 with BD_in=1 and PC_in=32'h0000_3008, EXL=0 -> IntExc=1. Next edge: Cause.ExcCode=10, BD=1, EPC=32'h0000_3004.
- HWInt and ExcCode_in=12 in the same cycle, with the interrupt enabled -> recorded ExcCode=0.
- With EXL=1, ExcCode_in=4 and HWInt active -> IntExc=0 and no register change. Then eret -> EXL=0 and IntExc reasserts the next cycle.
- mtc0 EPC with wdata=32'h0000_3107 in the same cycle as eret -> EPCout=32'h0000_3104 that cycle. Next edge: EPC=32'h0000_3104.
- mtc0 to 13 and to 15 -> no change. Read addr 15 -> PRID. Read addr 7 -> 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for coprocessor 0: register numbers, exception codes,
// field positions and small helpers that assemble register read values.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int IM_LSB  = 10;
    localparam int IM_MSB  = 15;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int IP_LSB  = 10;
    localparam int IP_MSB  = 15;
    localparam int EXC_LSB = 2;
    localparam int EXC_MSB = 6;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] r;
        r                = 32'h0000_0000;
        r[IM_MSB:IM_LSB] = im;
        r[EXL_BIT]       = exl;
        r[IE_BIT]        = ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] code);
        logic [31:0] r;
        r                  = 32'h0000_0000;
        r[BD_BIT]          = bd;
        r[IP_MSB:IP_LSB]   = ip;
        r[EXC_MSB:EXC_LSB] = code;
        return r;
    endfunction

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        logic [31:0] r;
        r = bd ? (pc - 32'd4) : pc;
        return r & WORD_MASK;
    endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt vs. exception arbitration and
// the IntExc/EPCout redirect interface to the PC register.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h2019_0701
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  ExcCode_in,
    input  logic        BD_in,
    input  logic [31:0] PC_in,
    input  logic        eret,
    output logic        IntExc,
    output logic [31:0] EPCout
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic int_req_s;
    logic exc_req_s;
    logic int_exc_s;
    logic mtc0_ok_s;
    logic epc_fwd_s;

    // Request arbitration and redirect outputs.
    always_comb begin
        int_req_s = ie_q & ~exl_q & (|(HWInt & im_q));
        exc_req_s = (ExcCode_in != 5'd0) & ~exl_q;
        int_exc_s = (int_req_s | exc_req_s) & reset;
        mtc0_ok_s = we & ~int_exc_s;
        epc_fwd_s = mtc0_ok_s & (addr == REG_EPC) & reset;
        IntExc    = int_exc_s;
        EPCout    = epc_fwd_s ? (wdata & WORD_MASK) : epc_q;
    end

    // Next-state: exception entry beats eret and mtc0; eret clears EXL after a write.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = HWInt;
        if (int_exc_s) begin
            exl_d     = 1'b1;
            exccode_d = int_req_s ? EXC_INT : ExcCode_in;
            bd_d      = BD_in;
            epc_d     = epc_target(PC_in, BD_in);
        end else begin
            if (mtc0_ok_s) begin
                case (addr)
                    REG_SR: begin
                        im_d  = wdata[IM_MSB:IM_LSB];
                        exl_d = wdata[EXL_BIT];
                        ie_d  = wdata[IE_BIT];
                    end
                    REG_EPC: epc_d = wdata & WORD_MASK;
                    default: epc_d = epc_q;
                endcase
            end else begin
                epc_d = epc_q;
            end
            exl_d = eret ? 1'b0 : exl_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    // mfc0 read mux.
    always_comb begin
        case (addr)
            REG_SR:    rdata = pack_sr(im_q, exl_q, ie_q);
            REG_CAUSE: rdata = pack_cause(bd_q, ip_q, exccode_q);
            REG_EPC:   rdata = epc_q;
            REG_PRID:  rdata = PRID;
            default:   rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Directed, table-driven bench for cp0: each row drives one cycle of inputs
// and checks the combinational outputs just before the next rising edge.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  HWInt;
    logic [4:0]  ExcCode_in;
    logic        BD_in;
    logic [31:0] PC_in;
    logic        eret;
    logic        IntExc;
    logic [31:0] EPCout;

    int checks;
    int failures;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  hw;
        logic [4:0]  exc;
        logic        bd;
        logic [31:0] pc;
        logic        eret;
        logic        x_intexc;
        logic [31:0] x_epcout;
        logic [31:0] x_rdata;
    } vec_t;

    vec_t vecs[$];

    cp0 #(.PRID(32'h2019_0701)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .HWInt(HWInt), .ExcCode_in(ExcCode_in), .BD_in(BD_in),
        .PC_in(PC_in), .eret(eret), .IntExc(IntExc), .EPCout(EPCout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic w, input logic [4:0] a,
                       input logic [31:0] wd, input logic [5:0] hw, input logic [4:0] exc,
                       input logic bd, input logic [31:0] pc, input logic er,
                       input logic xi, input logic [31:0] xe, input logic [31:0] xr);
        vec_t v;
        v.rst = rst; v.we = w; v.addr = a; v.wdata = wd; v.hw = hw; v.exc = exc;
        v.bd = bd; v.pc = pc; v.eret = er;
        v.x_intexc = xi; v.x_epcout = xe; v.x_rdata = xr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic w, input logic [4:0] a,
                         input logic [31:0] wd, input logic [5:0] hw, input logic [4:0] exc,
                         input logic bd, input logic [31:0] pc, input logic er);
        @(negedge clk);
        reset = rst; we = w; addr = a; wdata = wd; HWInt = hw;
        ExcCode_in = exc; BD_in = bd; PC_in = pc; eret = er;
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0; HWInt = 6'd0;
        ExcCode_in = 5'd0; BD_in = 1'b0; PC_in = 32'd0; eret = 1'b0;

        //   rst   we    addr   wdata          hw     exc    bd    pc             eret  IntExc EPCout         rdata
        add(1'b0, 1'b0, 5'd12, 32'h0,         6'h3F, 5'd12, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0);
        add(1'b0, 1'b0, 5'd13, 32'h0,         6'h3F, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0);
        add(1'b1, 1'b1, 5'd12, 32'h0000_FC01, 6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h04, 5'd0,  1'b0, 32'h0000_2000, 1'b0, 1'b1, 32'h0,         32'h0000_FC01);
        add(1'b1, 1'b0, 5'd13, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_2000, 32'h0000_1000);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_2000, 32'h0000_FC03);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd10, 1'b1, 32'h0000_3008, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_FC01);
        add(1'b1, 1'b0, 5'd13, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3004, 32'h8000_0028);
        add(1'b1, 1'b0, 5'd14, 32'h0,         6'h01, 5'd4,  1'b0, 32'h0000_9000, 1'b0, 1'b0, 32'h0000_3004, 32'h0000_3004);
        add(1'b1, 1'b0, 5'd13, 32'h0,         6'h01, 5'd0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3004, 32'h8000_0428);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h01, 5'd12, 1'b0, 32'h0000_4000, 1'b0, 1'b1, 32'h0000_3004, 32'h0000_FC01);
        add(1'b1, 1'b0, 5'd13, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_4000, 32'h0000_0400);
        add(1'b1, 1'b1, 5'd14, 32'h0000_3107, 6'h00, 5'd0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3104, 32'h0000_4000);
        add(1'b1, 1'b0, 5'd14, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3104, 32'h0000_3104);
        add(1'b1, 1'b1, 5'd13, 32'hFFFF_FFFF, 6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3104, 32'h0);
        add(1'b1, 1'b1, 5'd15, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3104, 32'h2019_0701);
        add(1'b1, 1'b0, 5'd13, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3104, 32'h0);
        add(1'b1, 1'b0, 5'd15, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3104, 32'h2019_0701);
        add(1'b1, 1'b0, 5'd7,  32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3104, 32'h0);
        // PC 0 in a delay slot wraps to the top of the address space.
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd5,  1'b1, 32'h0,         1'b0, 1'b1, 32'h0000_3104, 32'h0000_FC01);
        add(1'b1, 1'b0, 5'd14, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        add(1'b1, 1'b1, 5'd12, 32'h0,         6'h00, 5'd12, 1'b0, 32'h0000_5000, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_FC01);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_5000, 32'h0000_FC03);
        add(1'b1, 1'b1, 5'd12, 32'hFFFF_0403, 6'h00, 5'd0,  1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_5000, 32'h0000_FC03);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_5000, 32'h0000_0401);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd4,  1'b0, 32'h0000_6000, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_0401);
        add(1'b0, 1'b0, 5'd12, 32'h0,         6'h00, 5'd4,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_6000, 32'h0000_0403);
        add(1'b1, 1'b0, 5'd12, 32'h0,         6'h00, 5'd0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0);

        // Two reset cycles before the table starts.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 6'h00, 5'd0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 6'h00, 5'd0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hw,
                  vecs[i].exc, vecs[i].bd, vecs[i].pc, vecs[i].eret);
            check($sformatf("v%0d IntExc", i), {31'd0, IntExc}, {31'd0, vecs[i].x_intexc});
            check($sformatf("v%0d EPCout", i), EPCout, vecs[i].x_epcout);
            check($sformatf("v%0d rdata", i), rdata, vecs[i].x_rdata);
        end

        // Level-sensitive interrupt held across a handler: masked by EXL, retaken after eret.
        drive(1'b1, 1'b1, 5'd12, 32'h0000_0801, 6'h02, 5'd0, 1'b0, 32'h0, 1'b0);
        check("seq enable IntExc", {31'd0, IntExc}, 32'd0);
        drive(1'b1, 1'b0, 5'd12, 32'h0, 6'h02, 5'd0, 1'b0, 32'h0000_7004, 1'b0);
        check("seq take IntExc", {31'd0, IntExc}, 32'd1);
        drive(1'b1, 1'b0, 5'd14, 32'h0, 6'h02, 5'd0, 1'b0, 32'h0000_8000, 1'b1);
        check("seq masked IntExc", {31'd0, IntExc}, 32'd0);
        check("seq epc", rdata, 32'h0000_7004);
        drive(1'b1, 1'b0, 5'd13, 32'h0, 6'h02, 5'd0, 1'b0, 32'h0000_8000, 1'b0);
        check("seq retake IntExc", {31'd0, IntExc}, 32'd1);
        check("seq cause", rdata, 32'h0000_0800);
        drive(1'b1, 1'b0, 5'd14, 32'h0, 6'h00, 5'd0, 1'b0, 32'h0, 1'b0);
        check("seq epc2", rdata, 32'h0000_8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
